// File: rtl/vdp_port_ctrl.sv
// VDP Z80 port decoder: two-byte control latch, auto-incrementing VRAM/CRAM address,
// read-ahead buffer, register writes, status flags and INT_L. Option macro: VDP_LINE_INT_EN.
module vdp_port_ctrl #(
    parameter int         ADDR_W    = 14,
    parameter int         CRAM_AW   = 5,
    parameter int         NUM_REGS  = 11,
    parameter logic [7:0] DATA_PORT = 8'hBE,
    parameter logic [7:0] CTRL_PORT = 8'hBF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         addr_in,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    input  logic               IORQ_L,
    input  logic               RD_L,
    input  logic               WR_L,
    output logic               vram_req,
    output logic               vram_we,
    output logic [ADDR_W-1:0]  vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic               vram_gnt,
    input  logic [7:0]         vram_rdata,
    output logic               cram_we,
    output logic [CRAM_AW-1:0] cram_addr,
    output logic [7:0]         cram_wdata,
    output logic               reg_we,
    output logic [3:0]         reg_addr,
    output logic [7:0]         reg_data,
    input  logic               frame_int_set,
    input  logic               coll_set,
    input  logic               ovf_set,
    input  logic               frame_int_en,
    input  logic               line_int_en,
    input  logic               line_tick,
    input  logic [7:0]         line_reload,
    output logic               INT_L,
    output logic               overrun
);

    typedef enum logic [1:0] {IDLE, VRAM_PEND, WAIT_REL} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [1:0]          code_reg;
    logic [7:0]          rdbuf_reg;
    logic                first_reg;
    logic                rd_load_reg;
    logic                access_prev_reg;
    logic [2:0]          flag_reg;
    logic [2:0]          flag_next;
    logic [2:0]          flag_set;
    logic                line_pend_next;

    logic is_rd, is_wr, is_data, is_ctrl, access, detect;
    logic ctrl_rd, ctrl_wr, data_rd, data_wr;
    logic [ADDR_W-1:0] addr_inc;

    // RD_L takes precedence if both strobes are low
    assign is_rd   = ~IORQ_L & ~RD_L;
    assign is_wr   = ~IORQ_L & RD_L & ~WR_L;
    assign is_data = (addr_in == DATA_PORT);
    assign is_ctrl = (addr_in == CTRL_PORT);
    assign access  = (is_rd | is_wr) & (is_data | is_ctrl);
    assign detect  = access && (state_reg == IDLE);
    assign ctrl_rd = detect & is_ctrl & is_rd;
    assign ctrl_wr = detect & is_ctrl & is_wr;
    assign data_rd = detect & is_data & is_rd;
    assign data_wr = detect & is_data & is_wr;
    assign addr_inc  = addr_reg + 1'b1;
    assign vram_addr = addr_reg;

    // Status flags, bit 2 = frame, 1 = overflow, 0 = collision; a set pulse beats a read-clear
    assign flag_set = {frame_int_set, ovf_set, coll_set};
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_flag
            assign flag_next[gi] = ctrl_rd ? flag_set[gi] : (flag_reg[gi] | flag_set[gi]);
        end
    endgenerate

`ifdef VDP_LINE_INT_EN
    logic [7:0] line_cnt_reg;
    logic       line_pend_reg;

    assign line_pend_next = (ctrl_rd ? 1'b0 : line_pend_reg) |
                            (line_tick && (line_cnt_reg == 8'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt_reg  <= 8'd0;
            line_pend_reg <= 1'b0;
        end else begin
            line_pend_reg <= line_pend_next;
            if (frame_int_set)
                line_cnt_reg <= line_reload;
            else if (line_tick)
                line_cnt_reg <= (line_cnt_reg == 8'd0) ? line_reload : line_cnt_reg - 8'd1;
        end
    end
`else
    logic unused_line;
    assign unused_line    = ^{line_tick, line_reload};
    assign line_pend_next = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            code_reg        <= 2'd0;
            rdbuf_reg       <= 8'd0;
            first_reg       <= 1'b0;
            rd_load_reg     <= 1'b0;
            access_prev_reg <= 1'b0;
            flag_reg        <= 3'd0;
            data_out        <= 8'd0;
            vram_req        <= 1'b0;
            vram_we         <= 1'b0;
            vram_wdata      <= 8'd0;
            cram_we         <= 1'b0;
            cram_addr       <= '0;
            cram_wdata      <= 8'd0;
            reg_we          <= 1'b0;
            reg_addr        <= 4'd0;
            reg_data        <= 8'd0;
            INT_L           <= 1'b1;
            overrun         <= 1'b0;
        end else begin
            cram_we         <= 1'b0;
            reg_we          <= 1'b0;
            rd_load_reg     <= 1'b0;
            access_prev_reg <= access;
            flag_reg        <= flag_next;
            INT_L           <= ~((flag_next[2] & frame_int_en) | (line_pend_next & line_int_en));

            // A fresh strobe that begins outside IDLE can never be serviced
            if (access && !access_prev_reg && state_reg != IDLE)
                overrun <= 1'b1;

            if (rd_load_reg) begin
                rdbuf_reg <= vram_rdata;
                addr_reg  <= addr_inc;
            end

            case (state_reg)
                IDLE: begin
                    if (detect) begin
                        first_reg <= 1'b0;
                        state_reg <= WAIT_REL;
                        if (ctrl_wr && !first_reg) begin
                            addr_reg[7:0] <= data_in;
                            first_reg     <= 1'b1;
                        end else if (ctrl_wr) begin
                            code_reg             <= data_in[7:6];
                            addr_reg[ADDR_W-1:8] <= data_in[ADDR_W-9:0];
                            if (data_in[7:6] == 2'd0) begin
                                vram_req  <= 1'b1;
                                vram_we   <= 1'b0;
                                state_reg <= VRAM_PEND;
                            end else if (data_in[7:6] == 2'd2 &&
                                         32'(data_in[3:0]) < NUM_REGS) begin
                                reg_we   <= 1'b1;
                                reg_addr <= data_in[3:0];
                                reg_data <= addr_reg[7:0];
                            end
                        end else if (data_wr) begin
                            rdbuf_reg <= data_in;
                            if (code_reg == 2'd3) begin
                                cram_we    <= 1'b1;
                                cram_addr  <= addr_reg[CRAM_AW-1:0];
                                cram_wdata <= data_in;
                                addr_reg   <= addr_inc;
                            end else begin
                                vram_req   <= 1'b1;
                                vram_we    <= 1'b1;
                                vram_wdata <= data_in;
                                state_reg  <= VRAM_PEND;
                            end
                        end else if (data_rd) begin
                            data_out  <= rdbuf_reg;
                            vram_req  <= 1'b1;
                            vram_we   <= 1'b0;
                            state_reg <= VRAM_PEND;
                        end else if (ctrl_rd) begin
                            data_out <= {flag_reg, 5'b0};
                        end
                    end
                end
                VRAM_PEND: begin
                    if (vram_gnt) begin
                        vram_req  <= 1'b0;
                        state_reg <= WAIT_REL;
                        if (vram_we)
                            addr_reg <= addr_inc;
                        else
                            rd_load_reg <= 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (!access)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Directed testbench for vdp_port_ctrl: Z80 port cycles, VRAM/CRAM/register paths,
// status/interrupt behaviour, overrun and (when VDP_LINE_INT_EN is defined) line interrupts.
module tb_vdp_port_ctrl;

    localparam logic [7:0] DP = 8'hBE;
    localparam logic [7:0] CP = 8'hBF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr_in = 8'h00;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        IORQ_L = 1'b1, RD_L = 1'b1, WR_L = 1'b1;
    logic        vram_req, vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_gnt = 1'b0;
    logic [7:0]  vram_rdata = 8'h00;
    logic        cram_we;
    logic [4:0]  cram_addr;
    logic [7:0]  cram_wdata;
    logic        reg_we;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        frame_int_set = 1'b0, coll_set = 1'b0, ovf_set = 1'b0;
    logic        frame_int_en = 1'b0, line_int_en = 1'b0;
    logic        line_tick = 1'b0;
    logic [7:0]  line_reload = 8'h00;
    logic        INT_L, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int reg_we_cnt = 0, cram_we_cnt = 0;
    logic [3:0] last_reg_addr;
    logic [7:0] last_reg_data, last_cram_data;
    logic [4:0] last_cram_addr;
    logic [7:0] rd;

    vdp_port_ctrl dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in), .data_out(data_out),
        .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_gnt(vram_gnt), .vram_rdata(vram_rdata),
        .cram_we(cram_we), .cram_addr(cram_addr), .cram_wdata(cram_wdata),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
        .frame_int_set(frame_int_set), .coll_set(coll_set), .ovf_set(ovf_set),
        .frame_int_en(frame_int_en), .line_int_en(line_int_en),
        .line_tick(line_tick), .line_reload(line_reload),
        .INT_L(INT_L), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Strobe monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (reg_we) begin
            reg_we_cnt++;
            last_reg_addr = reg_addr;
            last_reg_data = reg_data;
        end
        if (cram_we) begin
            cram_we_cnt++;
            last_cram_addr = cram_addr;
            last_cram_data = cram_wdata;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] d);
        @(negedge clk);
        addr_in = port; data_in = d; IORQ_L = 1'b0; WR_L = 1'b0;
        repeat (2) @(negedge clk);
        IORQ_L = 1'b1; WR_L = 1'b1;
        @(negedge clk);
    endtask

    task automatic io_read(input logic [7:0] port, input logic pulse_frame, output logic [7:0] d);
        @(negedge clk);
        addr_in = port; IORQ_L = 1'b0; RD_L = 1'b0; frame_int_set = pulse_frame;
        @(negedge clk);
        frame_int_set = 1'b0;
        d = data_out;
        @(negedge clk);
        IORQ_L = 1'b1; RD_L = 1'b1;
        @(negedge clk);
    endtask

    task automatic grant();
        @(negedge clk);
        vram_gnt = 1'b1;
        @(negedge clk);
        vram_gnt = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_frame_set();
        @(negedge clk);
        frame_int_set = 1'b1;
        @(negedge clk);
        frame_int_set = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        line_tick = 1'b1;
        @(negedge clk);
        line_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("reset INT_L", INT_L, 1);
        check_val("reset vram_req", vram_req, 0);
        check_val("reset overrun", overrun, 0);
        check_val("reset data_out", data_out, 0);
        check_val("reset vram_addr", vram_addr, 0);

        // VRAM write at 0x0034
        io_write(CP, 8'h34);
        io_write(CP, 8'h40);
        check_val("code1 no req", vram_req, 0);
        check_val("code1 addr", vram_addr, 14'h0034);
        io_write(DP, 8'hAA);
        check_val("vwr req", vram_req, 1);
        check_val("vwr we", vram_we, 1);
        check_val("vwr addr", vram_addr, 14'h0034);
        check_val("vwr wdata", vram_wdata, 8'hAA);
        grant();
        check_val("vwr req drop", vram_req, 0);
        check_val("vwr addr inc", vram_addr, 14'h0035);

        // VRAM read-ahead at 0x3FFF with wrap
        io_write(CP, 8'hFF);
        io_write(CP, 8'h3F);
        check_val("vrd req", vram_req, 1);
        check_val("vrd we", vram_we, 0);
        check_val("vrd addr", vram_addr, 14'h3FFF);
        vram_rdata = 8'h5C;
        grant();
        check_val("vrd addr wrap", vram_addr, 14'h0000);
        io_read(DP, 1'b0, rd);
        check_val("data read 1", rd, 8'h5C);
        check_val("refill req", vram_req, 1);
        check_val("refill addr", vram_addr, 14'h0000);
        vram_rdata = 8'h11;
        grant();
        check_val("refill addr inc", vram_addr, 14'h0001);
        io_read(DP, 1'b0, rd);
        check_val("data read 2", rd, 8'h11);
        grant();
        check_val("refill2 addr inc", vram_addr, 14'h0002);

        // Register writes
        io_write(CP, 8'h07);
        io_write(CP, 8'h81);
        check_val("reg_we count", reg_we_cnt, 1);
        check_val("reg_addr", last_reg_addr, 4'd1);
        check_val("reg_data", last_reg_data, 8'h07);
        io_write(CP, 8'h07);
        io_write(CP, 8'h8C);
        check_val("reg idx 12 dropped", reg_we_cnt, 1);

        // Frame interrupt and status read
        frame_int_en = 1'b1;
        check_val("INT_L idle", INT_L, 1);
        pulse_frame_set();
        check_val("INT_L frame", INT_L, 0);
        io_read(CP, 1'b0, rd);
        check_val("status frame", rd, 8'h80);
        check_val("INT_L cleared", INT_L, 1);
        io_read(CP, 1'b1, rd);
        check_val("status coincident", rd, 8'h00);
        check_val("INT_L set wins", INT_L, 0);
        io_read(CP, 1'b0, rd);
        check_val("status retained", rd, 8'h80);
        check_val("INT_L cleared 2", INT_L, 1);
        @(negedge clk);
        coll_set = 1'b1; ovf_set = 1'b1;
        @(negedge clk);
        coll_set = 1'b0; ovf_set = 1'b0;
        check_val("INT_L no frame", INT_L, 1);
        io_read(CP, 1'b0, rd);
        check_val("status ovf coll", rd, 8'h60);
        io_read(CP, 1'b0, rd);
        check_val("status clear", rd, 8'h00);
        frame_int_en = 1'b0;

        // CRAM write
        io_write(CP, 8'h10);
        io_write(CP, 8'hC0);
        io_write(DP, 8'h3F);
        check_val("cram_we count", cram_we_cnt, 1);
        check_val("cram_addr", last_cram_addr, 5'h10);
        check_val("cram_wdata", last_cram_data, 8'h3F);
        check_val("cram no vram", vram_req, 0);
        check_val("cram addr inc", vram_addr, 14'h0011);

        // Overrun: second strobe while a write waits for grant
        io_write(CP, 8'h00);
        io_write(CP, 8'h40);
        io_write(DP, 8'h55);
        check_val("pre overrun", overrun, 0);
        io_write(DP, 8'h66);
        check_val("overrun set", overrun, 1);
        check_val("lost wdata", vram_wdata, 8'h55);
        grant();
        check_val("overrun addr", vram_addr, 14'h0001);
        check_val("overrun sticky", overrun, 1);

`ifdef VDP_LINE_INT_EN
        line_reload = 8'd2;
        line_int_en = 1'b1;
        pulse_frame_set();
        tick();
        check_val("line tick1", INT_L, 1);
        tick();
        check_val("line tick2", INT_L, 1);
        tick();
        check_val("line tick3", INT_L, 0);
        io_read(CP, 1'b0, rd);
        check_val("line status", rd, 8'h80);
        check_val("line cleared", INT_L, 1);
        line_int_en = 1'b0;
`else
        line_reload = 8'd0;
        line_int_en = 1'b1;
        tick();
        tick();
        tick();
        check_val("no line int", INT_L, 1);
        line_int_en = 1'b0;
`endif

        // Reset while a read is pending
        io_write(CP, 8'h00);
        io_write(CP, 8'h00);
        check_val("pend before rst", vram_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst drops req", vram_req, 0);
        check_val("rst clears overrun", overrun, 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
